tile_draw_sequencer: RTL
========================

// Module: tile_draw_sequencer
// PURPOSE
//  Initiator side of the glyph-drawer interface: walks a 4x4 puzzle board, and for each tile
//  clears a TILE x TILE square to background, then enables the selected number-glyph drawer
//  at the tile origin and forwards its returned stroke pixels to the VGA adapter plot port.
//  Sits between the game-state FSM (start/board/done) and the numberN glyph drawer instances.
// PARAMETERS
//  TILE          30   tile edge in pixels; tile origin = (X0 + col*TILE, Y0 + row*TILE)
//  X0            20   board left edge (x, 8 bits)
//  Y0            0    board top edge (y, 7 bits)
//  GLYPH_CYCLES  141  cycles one glyph drawer needs for a full pass (counter 0..140)
//  BG_COLOUR     3'b000  clear colour;  FG_COLOUR 3'b111  stroke colour
// PORTS
//  clk          in   1   clock
//  resetn       in   1   synchronous, active-low reset
//  start        in   1   request full-board redraw; sampled only in IDLE
//  board        in   64  tile values, nibble i = tile i (row = i/4, col = i%4); 0 = blank
//  busy         out  1   high from cycle after start accepted until DONE inclusive
//  done         out  1   one-cycle pulse when last tile finished
//  glyph_sel    out  4   value of current tile (selects which drawer's outputs are muxed)
//  glyph_x_org  out  8   current tile origin x, to drawer xIn
//  glyph_y_org  out  7   current tile origin y, to drawer yIn
//  glyph_en     out  1   drawer enable
//  glyph_resetn out  1   drawer synchronous reset (active low)
//  glyph_x      in   8   selected drawer xOut (absolute, combinational from its counter)
//  glyph_y      in   7   selected drawer yOut
//  plot         out  1   pixel write strobe to VGA adapter
//  x_out        out  8   pixel x;  y_out out 7 pixel y;  colour out 3 pixel colour
// BEHAVIOUR
//  Reset: state=IDLE, tile index=0, busy=0, done=0, plot=0, glyph_en=0, x_out=y_out=0,
//   colour=0; glyph_resetn=0 whenever resetn=0 (reset mid-redraw aborts, no done pulse).
//  IDLE: start=1 -> latch board into board_q, idx=0, go LOAD. board changes later are ignored.
//  LOAD (1 cyc): compute origin of tile idx, load glyph_sel=board_q[idx]; cx=cy=0; -> CLEAR.
//  CLEAR (TILE*TILE cyc): plot=1, colour=BG, x_out=org_x+cx, y_out=org_y+cy; cx counts
//   0..TILE-1 fastest, cy increments at cx wrap; after cx=cy=TILE-1:
//   -> GRST if glyph_sel!=0, else -> NEXT.
//  GRST (1 cyc): glyph_resetn=0, glyph_en=0, plot=0 so drawer counter starts at 0; -> GLYPH.
//  GLYPH (GLYPH_CYCLES cyc): glyph_en=1, plot=1, colour=FG, x_out=glyph_x, y_out=glyph_y
//   passed through combinationally (zero latency); cycle counter 0..GLYPH_CYCLES-1 -> NEXT.
//  NEXT (1 cyc): plot=0; idx==15 -> DONE, else idx+1 -> LOAD.
//  DONE (1 cyc): done=1, busy=1; -> IDLE (busy=0 next cycle). start in DONE ignored.
//  glyph_en=0 and glyph_resetn=1 outside GRST/GLYPH; plot=0 in IDLE/LOAD/GRST/NEXT/DONE.
//  Cycles per tile: blank 902, numbered 1044. All-numbered board: start edge to done = 16705.
//  Origin arithmetic unsigned, no wrap for defaults (max x 110+29, y 90+29).
//  start asserted while busy: ignored, no queuing. start held high in IDLE after DONE: new pass.
// TESTING
//  board=0 (all blank), start 1 cyc -> 16*900 plot pulses, all colour=0, glyph_en never 1,
//   done pulse exactly 14433 cycles after start edge.
//  board nibble0=5 only -> tile0 clear 900 px at (20..49,0..29), glyph_resetn low 1 cyc,
//   glyph_en high exactly 141 cycles, glyph_sel=5, then tiles 1..15 clear only.
//  all tiles nonzero -> 16 GRST pulses, done at cycle 16705, tile 15 origin (110,90).
//  start pulsed again at cycle 500 of a redraw -> ignored; exactly one done pulse.
//  resetn low mid-GLYPH of tile 6 -> next cycle busy=0, plot=0, glyph_resetn=0; new start
//   redraws from tile 0.
//  board changed after start accepted -> drawn values match board at start edge.

Source files
------------

// File: rtl/tile_draw_sequencer.sv
// Walks a 4x4 board: clears each tile to background, then runs the selected glyph
// drawer at the tile origin and forwards its stroke pixels to the VGA plot port.
module tile_draw_sequencer #(
  parameter int         TILE         = 30,
  parameter int         X0           = 20,
  parameter int         Y0           = 0,
  parameter int         GLYPH_CYCLES = 141,
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] FG_COLOUR    = 3'b111
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic [63:0] i_board,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_glyph_sel,
  output logic [7:0]  o_glyph_x_org,
  output logic [6:0]  o_glyph_y_org,
  output logic        o_glyph_en,
  output logic        o_glyph_resetn,
  input  logic [7:0]  i_glyph_x,
  input  logic [6:0]  i_glyph_y,
  output logic        o_plot,
  output logic [7:0]  o_x_out,
  output logic [6:0]  o_y_out,
  output logic [2:0]  o_colour
);

  localparam int CW = $clog2(TILE);
  localparam int GW = $clog2(GLYPH_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(TILE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GLYPH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_GRST, S_GLYPH, S_NEXT, S_DONE
  } state_t;

  state_t        r_state;
  logic [63:0]   r_board;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_cx;
  logic [CW-1:0] r_cy;
  logic [GW-1:0] r_gcnt;
  logic          r_busy;
  logic          r_done;
  logic          r_plot;
  logic [2:0]    r_colour;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic          r_en;
  logic          r_grstn;
  logic [3:0]    r_sel;
  logic [7:0]    r_xorg;
  logic [6:0]    r_yorg;
  logic [7:0]    w_orgx;
  logic [6:0]    w_orgy;

  function automatic logic [7:0] orgX(input logic [1:0] col);
    orgX = 8'(X0 + int'(col) * TILE);
  endfunction

  function automatic logic [6:0] orgY(input logic [1:0] row);
    orgY = 7'(Y0 + int'(row) * TILE);
  endfunction

  assign w_orgx = orgX(r_idx[1:0]);
  assign w_orgy = orgY(r_idx[3:2]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_board  <= '0;
      r_idx    <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_gcnt   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_colour <= 3'b000;
      r_x      <= '0;
      r_y      <= '0;
      r_en     <= 1'b0;
      r_grstn  <= 1'b1;
      r_sel    <= '0;
      r_xorg   <= '0;
      r_yorg   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_board <= i_board;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sel    <= r_board[{r_idx, 2'b00} +: 4];
          r_xorg   <= w_orgx;
          r_yorg   <= w_orgy;
          r_x      <= w_orgx;
          r_y      <= w_orgy;
          r_cx     <= '0;
          r_cy     <= '0;
          r_plot   <= 1'b1;
          r_colour <= BG_COLOUR;
          r_state  <= S_CLEAR;
        end
        // Raster scan of the tile: x runs fastest, y steps when x wraps.
        S_CLEAR: begin
          if (r_cx == C_LAST) begin
            r_cx <= '0;
            r_x  <= r_xorg;
            if (r_cy == C_LAST) begin
              r_plot <= 1'b0;
              if (r_sel != 4'd0) begin
                r_grstn <= 1'b0;
                r_state <= S_GRST;
              end else begin
                r_state <= S_NEXT;
              end
            end else begin
              r_cy <= r_cy + 1'b1;
              r_y  <= r_y + 7'd1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
            r_x  <= r_x + 8'd1;
          end
        end
        S_GRST: begin
          r_grstn  <= 1'b1;
          r_en     <= 1'b1;
          r_plot   <= 1'b1;
          r_colour <= FG_COLOUR;
          r_gcnt   <= '0;
          r_state  <= S_GLYPH;
        end
        S_GLYPH: begin
          if (r_gcnt == G_LAST) begin
            r_en    <= 1'b0;
            r_plot  <= 1'b0;
            r_state <= S_NEXT;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (r_idx == 4'd15) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Drawer pixels bypass the registers so strokes line up with the drawer counter.
  assign o_x_out        = (r_state == S_GLYPH) ? i_glyph_x : r_x;
  assign o_y_out        = (r_state == S_GLYPH) ? i_glyph_y : r_y;
  assign o_glyph_resetn = r_grstn & resetn;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_plot         = r_plot;
  assign o_colour       = r_colour;
  assign o_glyph_en     = r_en;
  assign o_glyph_sel    = r_sel;
  assign o_glyph_x_org  = r_xorg;
  assign o_glyph_y_org  = r_yorg;

endmodule
